quic_dec_bitreader: RTL and testbench

- Upstream feeder of the QUIC Golomb decode stage.
- Accepts 32-bit compressed words from the input word stream and keeps a 64-bit MSB-aligned bit buffer.
- Presents a 32-bit left-aligned window, `bitstream_output`, to the Golomb decoder.
- Consumes a variable number of bits (0..32) per cycle, as reported by the decoder's `golomb_len` or by the run-length logic.

---
 rtl/quic_dec_bitreader_pkg.sv | 18 +
 rtl/quic_bs_byteswap.sv | 22 ++
 rtl/quic_dec_bitreader.sv | 108 ++++++++++
 tb/tb_quic_dec_bitreader.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/quic_dec_bitreader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | quic_dec_bitreader_pkg : shared word width and bit-reader FSM states |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package quic_dec_bitreader_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        bs_idle  = 2'd0,
        bs_prime = 2'd1,
        bs_run   = 2'd2,
        bs_err   = 2'd3
    } bs_state_t;

endpackage
`default_nettype wire

// File: rtl/quic_bs_byteswap.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | quic_bs_byteswap : optional byte reversal of a 32-bit stream word    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module quic_bs_byteswap #(
    parameter bit EN = 1'b1
) (
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    generate
        if (EN) begin : g_swap
            assign word_out = {word_in[7:0], word_in[15:8], word_in[23:16], word_in[31:24]};
        end else begin : g_pass
            assign word_out = word_in;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/quic_dec_bitreader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | quic_dec_bitreader : 64-bit MSB-aligned bit buffer feeding the Golomb |
// | decoder. QUIC_BS_BYTE_SWAP_EN byte-reverses incoming words.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module quic_dec_bitreader
    import quic_dec_bitreader_pkg::*;
#(
    parameter int BUF_W = 64,
    parameter int CNT_W = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] word_i,
    input  logic              word_valid_i,
    output logic              word_ready_o,
    input  logic              consume_en,
    input  logic [5:0]        consume_len,
    output logic [WORD_W-1:0] bitstream_output,
    output logic              window_valid,
    output logic [31:0]       bits_consumed,
    output logic              err_o
);

`ifdef QUIC_BS_BYTE_SWAP_EN
    localparam bit SWAP_EN = 1'b1;
`else
    localparam bit SWAP_EN = 1'b0;
`endif

    bs_state_t          state, state_n;
    logic [BUF_W-1:0]   bit_buf, buf_s, buf_n;
    logic [CNT_W-1:0]   cnt, cnt_s, cnt_n;
    logic [31:0]        consumed_n;
    logic               err_n;
    logic [WORD_W-1:0]  word_app;
    logic               accept, do_consume, illegal;

    quic_bs_byteswap #(.EN(SWAP_EN)) u_byteswap (
        .word_in  (word_i),
        .word_out (word_app)
    );

    assign word_ready_o     = ((state == bs_prime) || (state == bs_run)) && (cnt <= CNT_W'(32));
    assign window_valid     = (state == bs_run) && (cnt >= CNT_W'(32));
    assign bitstream_output = bit_buf[BUF_W-1 -: WORD_W];

    assign accept     = word_valid_i && word_ready_o;
    assign illegal    = consume_en && (!window_valid || (consume_len > 6'd32));
    assign do_consume = consume_en && window_valid && (consume_len <= 6'd32);

    always_comb begin
        buf_s      = bit_buf;
        cnt_s      = cnt;
        buf_n      = bit_buf;
        cnt_n      = cnt;
        consumed_n = bits_consumed;
        err_n      = err_o;
        state_n    = state;

        if (start) begin
            buf_n      = '0;
            cnt_n      = '0;
            consumed_n = '0;
            err_n      = 1'b0;
            state_n    = bs_prime;
        end else if (illegal) begin
            // The buffer is frozen on an illegal consume, even if a word was offered.
            err_n   = 1'b1;
            state_n = bs_err;
        end else begin
            if (do_consume) begin
                buf_s      = bit_buf << consume_len;
                cnt_s      = cnt - CNT_W'(consume_len);
                consumed_n = bits_consumed + 32'(consume_len);
            end
            buf_n = buf_s;
            cnt_n = cnt_s;
            if (accept) begin
                buf_n = buf_s | ({word_app, {(BUF_W-WORD_W){1'b0}}} >> cnt_s);
                cnt_n = cnt_s + CNT_W'(32);
            end
            if ((state == bs_prime) && (cnt_n >= CNT_W'(32))) begin
                state_n = bs_run;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_buf       <= '0;
            cnt           <= '0;
            bits_consumed <= '0;
            err_o         <= 1'b0;
            state         <= bs_idle;
        end else begin
            bit_buf       <= buf_n;
            cnt           <= cnt_n;
            bits_consumed <= consumed_n;
            err_o         <= err_n;
            state         <= state_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quic_dec_bitreader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_quic_dec_bitreader : directed vector bench for the bit reader     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_quic_dec_bitreader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] word_i;
    logic        word_valid_i;
    logic        word_ready_o;
    logic        consume_en;
    logic [5:0]  consume_len;
    logic [31:0] bitstream_output;
    logic        window_valid;
    logic [31:0] bits_consumed;
    logic        err_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    quic_dec_bitreader dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .word_i           (word_i),
        .word_valid_i     (word_valid_i),
        .word_ready_o     (word_ready_o),
        .consume_en       (consume_en),
        .consume_len      (consume_len),
        .bitstream_output (bitstream_output),
        .window_valid     (window_valid),
        .bits_consumed    (bits_consumed),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        ce;
        logic [5:0]  cl;
        logic        wv;
        logic [31:0] w;
        logic [31:0] e_win;
        logic        e_wv;
        logic        e_rdy;
        logic        e_err;
        logic [31:0] e_bc;
    } vec_t;

    // Words are pre-swapped so the DUT always appends the table value.
    function automatic logic [31:0] to_dut(input logic [31:0] w);
`ifdef QUIC_BS_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic vec_t mk(input logic st, input logic ce, input logic [5:0] cl,
                                input logic wv, input logic [31:0] w, input logic [31:0] e_win,
                                input logic e_wv, input logic e_rdy, input logic e_err,
                                input logic [31:0] e_bc);
        vec_t v;
        v.st = st; v.ce = ce; v.cl = cl; v.wv = wv; v.w = w;
        v.e_win = e_win; v.e_wv = e_wv; v.e_rdy = e_rdy; v.e_err = e_err; v.e_bc = e_bc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic drive(input logic st, input logic ce, input logic [5:0] cl,
                         input logic wv, input logic [31:0] w);
        @(negedge clk);
        start = st; consume_en = ce; consume_len = cl; word_valid_i = wv; word_i = w;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[20];
    logic [31:0] exp_word;

    initial begin
        //            st ce cl  wv word          win           wv rdy err bc
        vecs[0]  = mk(1, 0, 0,  0, 32'h0,        32'h00000000, 0, 1, 0, 0);
        vecs[1]  = mk(0, 0, 0,  1, 32'hF0000001, 32'hF0000001, 1, 1, 0, 0);
        vecs[2]  = mk(0, 0, 0,  1, 32'hA5A5A5A5, 32'hF0000001, 1, 0, 0, 0);
        vecs[3]  = mk(0, 1, 4,  0, 32'h0,        32'h0000001A, 1, 0, 0, 4);
        vecs[4]  = mk(0, 1, 0,  0, 32'h0,        32'h0000001A, 1, 0, 0, 4);
        vecs[5]  = mk(0, 1, 28, 0, 32'h0,        32'hA5A5A5A5, 1, 1, 0, 32);
        vecs[6]  = mk(0, 1, 33, 0, 32'h0,        32'hA5A5A5A5, 0, 0, 1, 32);
        vecs[7]  = mk(0, 1, 1,  0, 32'h0,        32'hA5A5A5A5, 0, 0, 1, 32);
        vecs[8]  = mk(0, 0, 0,  1, 32'h12345678, 32'hA5A5A5A5, 0, 0, 1, 32);
        vecs[9]  = mk(1, 1, 4,  1, 32'h12345678, 32'h00000000, 0, 1, 0, 0);
        vecs[10] = mk(0, 1, 3,  0, 32'h0,        32'h00000000, 0, 0, 1, 0);
        vecs[11] = mk(1, 0, 0,  0, 32'h0,        32'h00000000, 0, 1, 0, 0);
        vecs[12] = mk(0, 0, 0,  1, 32'h12345678, 32'h12345678, 1, 1, 0, 0);
        vecs[13] = mk(0, 0, 0,  1, 32'h9ABCDEF0, 32'h12345678, 1, 0, 0, 0);
        vecs[14] = mk(0, 1, 30, 0, 32'h0,        32'h26AF37BC, 1, 0, 0, 30);
        vecs[15] = mk(0, 1, 5,  0, 32'h0,        32'hD5E6F780, 0, 1, 0, 35);
        vecs[16] = mk(0, 0, 0,  1, 32'hCAFEBABE, 32'hD5E6F786, 1, 0, 0, 35);
        vecs[17] = mk(0, 1, 32, 1, 32'h11111111, 32'h57F5D5F0, 0, 1, 0, 67);
        vecs[18] = mk(0, 0, 0,  0, 32'h0,        32'h57F5D5F0, 0, 1, 0, 67);
        vecs[19] = mk(1, 0, 0,  0, 32'h0,        32'h00000000, 0, 1, 0, 0);

        reset_n = 1'b0; start = 1'b0; consume_en = 1'b0; consume_len = '0;
        word_valid_i = 1'b0; word_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_window", bitstream_output, 32'h0);
        chk("reset_wvalid", 32'(window_valid), 32'h0);
        chk("reset_ready",  32'(word_ready_o), 32'h0);
        chk("reset_err",    32'(err_o), 32'h0);
        chk("reset_bc",     bits_consumed, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].st, vecs[i].ce, vecs[i].cl, vecs[i].wv, to_dut(vecs[i].w));
            chk($sformatf("v%0d_window", i), bitstream_output, vecs[i].e_win);
            chk($sformatf("v%0d_wvalid", i), 32'(window_valid), 32'(vecs[i].e_wv));
            chk($sformatf("v%0d_ready", i),  32'(word_ready_o), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_err", i),    32'(err_o), 32'(vecs[i].e_err));
            chk($sformatf("v%0d_bc", i),     bits_consumed, vecs[i].e_bc);
        end

        // Sustained 32 bits/cycle: each accepted word becomes the next window.
        for (int k = 0; k < 10; k++) begin
            exp_word = 32'h1000_0000 + 32'(k) * 32'h0101_0101;
            drive(1'b0, window_valid, 6'd32, 1'b1, to_dut(exp_word));
            chk($sformatf("stream%0d_wvalid", k), 32'(window_valid), 32'h1);
            chk($sformatf("stream%0d_window", k), bitstream_output, exp_word);
        end
        chk("stream_bc", bits_consumed, 32'd288);

        // Raw word check of the append byte order.
        drive(1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 6'd0, 1'b1, 32'h11223344);
`ifdef QUIC_BS_BYTE_SWAP_EN
        chk("byte_order", bitstream_output, 32'h44332211);
`else
        chk("byte_order", bitstream_output, 32'h11223344);
`endif
        drive(1'b0, 1'b0, 6'd0, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
